// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 joystick serial transmitter.
// Optional input filter is enabled with JOY_DB15_TX_FILT_EN (see joy_db15_sync).
package joy_db15_pkg;

    localparam int FRAME_BITS       = 32;
    localparam int PLAYER_BITS      = 16;
    localparam int DEF_IDLE_TIMEOUT = 1048576;
    localparam int DEF_FILT_LEN     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit 0 of each player lands at the MSB end of its half so it leaves first.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [PLAYER_BITS-1:0] p1,
        input logic [PLAYER_BITS-1:0] p2
    );
        logic [FRAME_BITS-1:0] w;
        for (int i = 0; i < PLAYER_BITS; i++) begin
            w[FRAME_BITS-1-i]  = ~p1[i];
            w[PLAYER_BITS-1-i] = ~p2[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/joy_db15_sync.sv
// Pin conditioner: 2-flop synchronizer, optional FILT_LEN stability filter
// (built only when JOY_DB15_TX_FILT_EN is defined), and rise/fall detector.
module joy_db15_sync
    import joy_db15_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic flt;
    logic edge_prev;

    // Stage 0/1: metastability hardening; idle-high so reset never fakes an edge
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

`ifdef JOY_DB15_TX_FILT_EN
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [CW-1:0] stab_cnt;

    // Stage 2: accept a new level only after FILT_LEN matching samples
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            flt      <= 1'b1;
            stab_cnt <= '0;
        end else if (sync_p1 == flt) begin
            stab_cnt <= '0;
        end else if (stab_cnt == CW'(FILT_LEN - 1)) begin
            flt      <= sync_p1;
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end
`else
    localparam int unused_filt_len = FILT_LEN;

    assign flt = sync_p1;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            edge_prev <= 1'b1;
        end else begin
            edge_prev <= flt;
        end
    end

    // Edges stay combinational so the pin-to-data latency is exactly four clocks
    assign level = flt;
    assign rise  = flt & ~edge_prev;
    assign fall  = ~flt & edge_prev;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick transmitter: serialises two 16-button pads to the host on
// JOY_LOAD/JOY_CLK. Define JOY_DB15_TX_FILT_EN to add the input glitch filter.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int FILT_LEN     = DEF_FILT_LEN,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                   MCLK,
    input  logic                   RESET,
    input  logic [PLAYER_BITS-1:0] joystick1,
    input  logic [PLAYER_BITS-1:0] joystick2,
    input  logic                   JOY_CLK,
    input  logic                   JOY_LOAD,
    output logic                   JOY_DATA,
    output logic                   frame_done,
    output logic                   link_active
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    state_e                  state;
    logic [FRAME_BITS-1:0]   sr;
    logic [5:0]              bit_cnt;
    logic [IW-1:0]           idle_cnt;
    logic                    load_seen;

    logic clk_lvl, clk_rise, clk_fall;
    logic load_lvl, load_rise, load_fall;
    logic unused_sync;

    function automatic logic [5:0] sat_bits(input logic [5:0] c);
        return (c == 6'(FRAME_BITS)) ? c : c + 6'd1;
    endfunction

    function automatic logic [IW-1:0] sat_idle(input logic [IW-1:0] c);
        return (c == IW'(IDLE_TIMEOUT)) ? c : c + 1'b1;
    endfunction

    joy_db15_sync #(.FILT_LEN(FILT_LEN)) u_sync_clk (
        .clk_sys (MCLK),
        .rst     (RESET),
        .pin     (JOY_CLK),
        .level   (clk_lvl),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    joy_db15_sync #(.FILT_LEN(FILT_LEN)) u_sync_load (
        .clk_sys (MCLK),
        .rst     (RESET),
        .pin     (JOY_LOAD),
        .level   (load_lvl),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    assign unused_sync = &{1'b0, clk_lvl, clk_fall, load_rise};

    // Stage 3: frame FSM and shift register; a low LOAD overrides everything
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            sr         <= '1;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            JOY_DATA   <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            JOY_DATA   <= (state == ST_IDLE) | sr[FRAME_BITS-1];
            if (!load_lvl) begin
                state   <= ST_LOAD;
                sr      <= frame_word(joystick1, joystick2);
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_LOAD: state <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (clk_rise) begin
                            sr      <= {sr[FRAME_BITS-2:0], 1'b1};
                            bit_cnt <= sat_bits(bit_cnt);
                            if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                                state      <= ST_DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (clk_rise) begin
                            sr      <= {sr[FRAME_BITS-2:0], 1'b1};
                            bit_cnt <= sat_bits(bit_cnt);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            idle_cnt  <= '0;
            load_seen <= 1'b0;
        end else if (load_fall) begin
            idle_cnt  <= '0;
            load_seen <= 1'b1;
        end else begin
            idle_cnt  <= sat_idle(idle_cnt);
        end
    end

    assign link_active = load_seen && (idle_cnt < IW'(IDLE_TIMEOUT));

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx; works with or without JOY_DB15_TX_FILT_EN.
module tb_joy_db15_tx;
    import joy_db15_pkg::*;

    localparam int FILT = 3;
    localparam int TMO  = 2000;
`ifdef JOY_DB15_TX_FILT_EN
    localparam int LAT = 4 + FILT;
`else
    localparam int LAT = 4;
`endif

    logic        MCLK;
    logic        RESET;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic        frame_done;
    logic        link_active;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    joy_db15_tx #(.FILT_LEN(FILT), .IDLE_TIMEOUT(TMO)) dut (
        .MCLK        (MCLK),
        .RESET       (RESET),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .JOY_CLK     (JOY_CLK),
        .JOY_LOAD    (JOY_LOAD),
        .JOY_DATA    (JOY_DATA),
        .frame_done  (frame_done),
        .link_active (link_active)
    );

    initial MCLK = 1'b0;
    always #10 MCLK = ~MCLK;

    always @(posedge MCLK) if (frame_done === 1'b1) fd_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_load(input logic [15:0] j1, input logic [15:0] j2);
        joystick1 = j1;
        joystick2 = j2;
        JOY_LOAD = 1'b0;
        tick(LAT + 2);
        JOY_LOAD = 1'b1;
        tick(LAT + 2);
    endtask

    task automatic host_clk(output logic b);
        JOY_CLK = 1'b1;
        tick(LAT + 2);
        b = JOY_DATA;
        JOY_CLK = 1'b0;
        tick(LAT + 2);
    endtask

    // word[k] holds serial bit k; tail is the AND of every bit after the 32nd
    task automatic read_frame(input int n, output logic [31:0] word, output logic tail);
        logic b;
        word = '0;
        tail = 1'b1;
        word[0] = JOY_DATA;
        for (int k = 1; k <= n; k++) begin
            host_clk(b);
            if (k < 32) word[k] = b;
            else tail &= b;
        end
    endtask

    logic [31:0] w;
    logic        t;
    logic        b;
    int          fd0;

    initial begin
        RESET = 1'b1;
        joystick1 = 16'h0001;
        joystick2 = 16'h0000;
        JOY_CLK = 1'b0;
        JOY_LOAD = 1'b1;
        tick(4);
        check("rst_data", JOY_DATA, 1'b1);
        check("rst_done", frame_done, 1'b0);
        check("rst_link", link_active, 1'b0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        RESET = 1'b0;
        tick(LAT + 2);
        check("idle_data", JOY_DATA, 1'b1);

        // Exact latency of LOAD fall and CLK rise to JOY_DATA
        JOY_LOAD = 1'b0;
        tick(LAT - 1);
        check("lat_load_early", JOY_DATA, 1'b1);
        tick(1);
        check("lat_load_edge", JOY_DATA, 1'b0);
        check("load_state", 32'(dut.state), 32'(ST_LOAD));
        check("link_up", link_active, 1'b1);
        JOY_LOAD = 1'b1;
        tick(LAT + 2);
        check("shift_state", 32'(dut.state), 32'(ST_SHIFT));
        JOY_CLK = 1'b1;
        tick(LAT - 1);
        check("lat_clk_early", JOY_DATA, 1'b0);
        tick(1);
        check("lat_clk_edge", JOY_DATA, 1'b1);
        JOY_CLK = 1'b0;
        tick(LAT + 2);

        // P1 bit0 pressed; frame_done only on the 32nd rise
        fd0 = fd_cnt;
        host_load(16'h0001, 16'h0000);
        check("abort_no_done", fd_cnt - fd0, 0);
        read_frame(31, w, t);
        check("done_before_32", fd_cnt - fd0, 0);
        host_clk(b);
        w[31] = 1'b0;
        check("frame_p1b0", w | {b ? 1'b0 : 1'b1, 31'h0} | 32'h8000_0000, 32'hFFFF_FFFE);
        check("after32_data", b, 1'b1);
        check("done_once", fd_cnt - fd0, 1);
        check("done_state", 32'(dut.state), 32'(ST_DONE));

        // P2 bit15 pressed: only the last serial bit is low
        fd0 = fd_cnt;
        host_load(16'h0000, 16'h8000);
        read_frame(32, w, t);
        check("frame_p2b15", w, 32'h7FFF_FFFF);
        check("frame_p2_done", fd_cnt - fd0, 1);

        host_load(16'hA5C3, 16'h0F0F);
        read_frame(32, w, t);
        check("frame_mixed", w, 32'hF0F0_5A3C);

        // LOAD low during the 10th rise wins over the shift
        fd0 = fd_cnt;
        host_load(16'h0001, 16'h0000);
        read_frame(9, w, t);
        JOY_LOAD = 1'b0;
        JOY_CLK = 1'b1;
        tick(LAT + 2);
        check("prio_state", 32'(dut.state), 32'(ST_LOAD));
        check("prio_bitcnt", 32'(dut.bit_cnt), 0);
        check("prio_data", JOY_DATA, 1'b0);
        JOY_CLK = 1'b0;
        tick(LAT + 2);
        JOY_LOAD = 1'b1;
        tick(LAT + 2);
        check("prio_no_done", fd_cnt - fd0, 0);
        read_frame(32, w, t);
        check("prio_restart", w, 32'hFFFF_FFFE);
        check("prio_done", fd_cnt - fd0, 1);

        // 40 rises after one load: tail is all ones, counter saturates
        fd0 = fd_cnt;
        host_load(16'h0001, 16'h0000);
        read_frame(40, w, t);
        check("over_frame", w, 32'hFFFF_FFFE);
        check("over_tail", t, 1'b1);
        check("over_bitcnt", 32'(dut.bit_cnt), 32);
        check("over_done", fd_cnt - fd0, 1);

        // Reset in mid-frame, then a clean frame
        host_load(16'h0000, 16'h0000);
        read_frame(12, w, t);
        RESET = 1'b1;
        tick(1);
        check("mrst_data", JOY_DATA, 1'b1);
        check("mrst_state", 32'(dut.state), 32'(ST_IDLE));
        check("mrst_bitcnt", 32'(dut.bit_cnt), 0);
        check("mrst_link", link_active, 1'b0);
        RESET = 1'b0;
        tick(LAT + 2);
        check("mrst_idle", JOY_DATA, 1'b1);
        fd0 = fd_cnt;
        host_load(16'h1234, 16'hFEDC);
        read_frame(32, w, t);
        check("mrst_frame", w, 32'h0123_EDCB);
        check("mrst_done", fd_cnt - fd0, 1);

`ifdef JOY_DB15_TX_FILT_EN
        // Two-sample CLK glitch is rejected by the filter
        host_load(16'h0001, 16'h0000);
        JOY_CLK = 1'b1;
        tick(2);
        JOY_CLK = 1'b0;
        tick(LAT + 4);
        check("glitch_bitcnt", 32'(dut.bit_cnt), 0);
        check("glitch_data", JOY_DATA, 1'b0);
        host_clk(b);
        check("glitch_then_shift", b, 1'b1);
`endif

        // Link watchdog
        JOY_LOAD = 1'b0;
        tick(LAT + 2);
        JOY_LOAD = 1'b1;
        check("link_fresh", link_active, 1'b1);
        tick(TMO - 100);
        check("link_hold", link_active, 1'b1);
        tick(200);
        check("link_drop", link_active, 1'b0);
        check("idle_sat", 32'(dut.idle_cnt), TMO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
